// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
//   bus_cmd_e     : MEM-stage bus command encoding (3 is unused and decodes as no-op)
//   sb_entry_t    : store-buffer entry {word index, data}
//   drain_state_e : drain FSM states
//   sat_inc       : saturating 32-bit increment for the optional statistics counters
package dmem_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  // Widest possible word index (addr[31:2]); entries hold the index already reduced
  // modulo the array depth, zero-extended to this width.
  localparam int unsigned WordIdxW = 30;

  typedef struct packed {
    logic [WordIdxW-1:0] index;
    logic [31:0]         data;
  } sb_entry_t;

  typedef enum logic {
    StIdle,
    StWrite
  } drain_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular FIFO of pending stores with a combinational youngest-match forward lookup.
// Ports:
//   clk, rst (async, active-low)
//   push, push_entry : enqueue at tail on the clock edge (caller guarantees space or a pop)
//   pop              : dequeue head on the clock edge
//   head_entry       : oldest entry (valid while count != 0)
//   count/full/empty : occupancy
//   lookup_index     : word index to search
//   hit, hit_data    : youngest valid entry matching lookup_index
module store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  sb_entry_t                 push_entry,
  input  logic                      pop,
  output sb_entry_t                 head_entry,
  output logic [$clog2(SB_DEPTH):0] count,
  output logic                      full,
  output logic                      empty,
  input  logic [WordIdxW-1:0]       lookup_index,
  output logic                      hit,
  output logic [31:0]               hit_data
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t       entries_q [SB_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] slot;

  // Pointers wrap naturally since SB_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= push_entry;
  end

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  // The head (possibly mid-drain) stays searchable until it is popped.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      slot = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (entries_q[slot].index == lookup_index)) begin
        hit      = 1'b1;
        hit_data = entries_q[slot].data;
      end
    end
  end

  assign head_entry = entries_q[head_q];
  assign count      = count_q;
  assign full       = (count_q == CntW'(SB_DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage bus. Loads are answered combinationally,
// stores go into a store buffer that a drain FSM retires into the word array through a
// write port busy DRAIN_CYCLES cycles per store. Loads forward from the buffer.
// Optional feature: define DMEM_STATS_EN to add saturating event counters.
// Ports:
//   clk, rst (async, active-low)
//   proc2Dmem_addr, proc2Dmem_command, proc2mem_data : bus request
//   mem2proc_data : load data, same cycle; 0 when not a load
//   sb_count, sb_empty, sb_full : store-buffer occupancy
//   drain_busy    : drain FSM writing
//   overflow      : sticky, a store was dropped
//   stat_loads, stat_stores, stat_fwd_hits, stat_drops : only with DMEM_STATS_EN
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned SB_DEPTH     = 4,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               proc2Dmem_addr,
  input  logic [1:0]                proc2Dmem_command,
  input  logic [31:0]               proc2mem_data,
  output logic [31:0]               mem2proc_data,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty,
  output logic                      sb_full,
  output logic                      drain_busy,
  output logic                      overflow
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]               stat_loads,
  output logic [31:0]               stat_stores,
  output logic [31:0]               stat_fwd_hits,
  output logic [31:0]               stat_drops
`endif
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam int unsigned DcW  = $clog2(DRAIN_CYCLES + 1);

  logic [31:0]         mem_q [MEM_WORDS];
  logic [IdxW-1:0]     word_idx;
  logic                is_load, is_store;
  logic                push, pop, drop;
  sb_entry_t           push_entry, head_entry;
  logic                fwd_hit;
  logic [31:0]         fwd_data;
  drain_state_e        state_q, state_d;
  logic [DcW-1:0]      drain_cnt_q, drain_cnt_d;
  logic                overflow_q;
  logic                unused_bits;

  assign word_idx = proc2Dmem_addr[IdxW+1:2];
  assign is_load  = (proc2Dmem_command == BUS_LOAD);
  assign is_store = (proc2Dmem_command == BUS_STORE);

  // A full buffer still accepts a store on the edge where the head retires.
  assign pop  = (state_q == StWrite) && (drain_cnt_q == '0);
  assign push = is_store && (!sb_full || pop);
  assign drop = is_store && !push;

  assign push_entry.index = WordIdxW'(word_idx);
  assign push_entry.data  = proc2mem_data;

  store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .head_entry   (head_entry),
    .count        (sb_count),
    .full         (sb_full),
    .empty        (sb_empty),
    .lookup_index (WordIdxW'(word_idx)),
    .hit          (fwd_hit),
    .hit_data     (fwd_data)
  );

  // Drain FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    drain_busy  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!sb_empty) begin
          state_d     = StWrite;
          drain_cnt_d = DcW'(DRAIN_CYCLES - 1);
        end
      end
      StWrite: begin
        drain_busy = 1'b1;
        if (drain_cnt_q == '0) begin
          // Entries left after this pop: the others already held, or one arriving now.
          if ((sb_count > 1) || push) begin
            drain_cnt_d = DcW'(DRAIN_CYCLES - 1);
          end else begin
            state_d = StIdle;
          end
        end else begin
          drain_cnt_d = drain_cnt_q - DcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Array is never reset. A reset mid-drain forces StIdle asynchronously, so pop drops
  // and the abandoned write never lands.
  always_ff @(posedge clk) begin
    if (pop) mem_q[head_entry.index[IdxW-1:0]] <= head_entry.data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end
  assign overflow = overflow_q;

  always_comb begin
    mem2proc_data = '0;
    if (is_load) mem2proc_data = fwd_hit ? fwd_data : mem_q[word_idx];
  end

  // Address bits outside the word index are intentionally ignored.
  assign unused_bits = ^{proc2Dmem_addr[1:0], proc2Dmem_addr[31:IdxW+2],
                         head_entry.index[WordIdxW-1:IdxW]};

`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads_q, stat_stores_q, stat_fwd_hits_q, stat_drops_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loads_q    <= '0;
      stat_stores_q   <= '0;
      stat_fwd_hits_q <= '0;
      stat_drops_q    <= '0;
    end else begin
      if (is_load)            stat_loads_q    <= sat_inc(stat_loads_q);
      if (push)               stat_stores_q   <= sat_inc(stat_stores_q);
      if (is_load && fwd_hit) stat_fwd_hits_q <= sat_inc(stat_fwd_hits_q);
      if (drop)               stat_drops_q    <= sat_inc(stat_drops_q);
    end
  end

  assign stat_loads    = stat_loads_q;
  assign stat_stores   = stat_stores_q;
  assign stat_fwd_hits = stat_fwd_hits_q;
  assign stat_drops    = stat_drops_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (MEM_WORDS=1024, SB_DEPTH=4,
// DRAIN_CYCLES=3). Inputs change 1 time unit after a rising edge; outputs are
// checked 1 unit later, well before the next edge.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  cmd;
  logic [2:0]  sb_count;
  logic        sb_empty, sb_full, drain_busy, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_WORDS    (1024),
    .SB_DEPTH     (4),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2Dmem_addr    (addr),
    .proc2Dmem_command (cmd),
    .proc2mem_data     (wdata),
    .mem2proc_data     (rdata),
    .sb_count          (sb_count),
    .sb_empty          (sb_empty),
    .sb_full           (sb_full),
    .drain_busy        (drain_busy),
    .overflow          (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    cmd   = c;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(BUS_STORE, a, d);
    tick();
  endtask

  task automatic wait_empty(input string tag, input int max_cycles);
    int n = 0;
    drive(BUS_NONE, 32'h0, 32'h0);
    while (!sb_empty && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb_empty), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    drive(BUS_NONE, 32'h0, 32'h0);
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_full", 32'(sb_full), 32'd0);
    chk("rst_busy", 32'(drain_busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_none_data", rdata, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Preload the array through the normal store path
    store(32'h40, 32'hDEAD_BEEF);
    store(32'h20, 32'h0000_0A0A);
    store(32'h10, 32'h1010_1010);
    wait_empty("preload_drain", 40);

    // 1: load from array, idle
    drive(BUS_LOAD, 32'h40, 32'h0);
    chk("t1_load", rdata, 32'hDEAD_BEEF);
    chk("t1_empty", 32'(sb_empty), 32'd1);
    chk("t1_busy", 32'(drain_busy), 32'd0);

    // 2: store then load; retires on the 4th edge after the store
    store(32'h100, 32'h1111_1111);                  // E0
    drive(BUS_LOAD, 32'h100, 32'h0);
    chk("t2_fwd", rdata, 32'h1111_1111);
    chk("t2_count1", 32'(sb_count), 32'd1);
    tick();                                         // E1
    tick();                                         // E2
    tick();                                         // E3
    chk("t2_busy_e3", 32'(drain_busy), 32'd1);
    chk("t2_count_e3", 32'(sb_count), 32'd1);
    chk("t2_fwd_retire_cycle", rdata, 32'h1111_1111);
    tick();                                         // E4: array write
    chk("t2_count_e4", 32'(sb_count), 32'd0);
    chk("t2_busy_e4", 32'(drain_busy), 32'd0);
    chk("t2_array", rdata, 32'h1111_1111);

    // 3: same-address ordering
    store(32'h8, 32'h1);
    store(32'h8, 32'h2);
    drive(BUS_LOAD, 32'h8, 32'h0);
    chk("t3_count", 32'(sb_count), 32'd2);
    chk("t3_fwd_young", rdata, 32'h2);
    wait_empty("t3_drain", 40);
    drive(BUS_LOAD, 32'h8, 32'h0);
    chk("t3_array", rdata, 32'h2);

    // 4A: from idle, 5th back-to-back store lands on the first pop edge -> accepted
    store(32'h0, 32'hA0);
    store(32'h4, 32'hA1);
    store(32'h8, 32'hA2);
    store(32'hC, 32'hA3);                           // E3: buffer full
    chk("t4a_full", 32'(sb_full), 32'd1);
    store(32'h10, 32'hA4);                          // E4: push + pop
    drive(BUS_LOAD, 32'h10, 32'h0);
    chk("t4a_count", 32'(sb_count), 32'd4);
    chk("t4a_ovf", 32'(overflow), 32'd0);
    chk("t4a_fwd", rdata, 32'hA4);
    wait_empty("t4a_drain", 60);
    drive(BUS_LOAD, 32'h10, 32'h0);
    chk("t4a_array", rdata, 32'hA4);

    // 4B: one leading store shifts the pop edges so the 5th store hits a full buffer
    store(32'h40, 32'hDEAD_BEEF);                   // E0
    drive(BUS_NONE, 32'h0, 32'h0);
    tick();                                         // E1
    store(32'h0, 32'hB0);                           // E2
    store(32'h4, 32'hB1);                           // E3
    store(32'h8, 32'hB2);                           // E4: pop of leading entry
    store(32'hC, 32'hB3);                           // E5: full
    store(32'h10, 32'hB4);                          // E6: no pop -> dropped
    drive(BUS_LOAD, 32'h10, 32'h0);
    chk("t4b_count", 32'(sb_count), 32'd4);
    chk("t4b_full", 32'(sb_full), 32'd1);
    chk("t4b_ovf", 32'(overflow), 32'd1);
    chk("t4b_dropped_old", rdata, 32'hA4);
    drive(BUS_LOAD, 32'hC, 32'h0);
    chk("t4b_fwd", rdata, 32'hB3);
    wait_empty("t4b_drain", 60);
    chk("t4b_ovf_sticky", 32'(overflow), 32'd1);
    drive(BUS_LOAD, 32'h10, 32'h0);
    chk("t4b_array_old", rdata, 32'hA4);
    drive(BUS_LOAD, 32'h0, 32'h0);
    chk("t4b_array_b0", rdata, 32'hB0);

    // 5: reset mid-drain abandons the write
    store(32'h20, 32'hAA);                          // E0
    drive(BUS_NONE, 32'h0, 32'h0);
    tick();                                         // E1: WRITE
    tick();                                         // E2
    chk("t5_busy", 32'(drain_busy), 32'd1);
    rst = 1'b0;
    drive(BUS_LOAD, 32'h20, 32'h0);
    chk("t5_rst_count", 32'(sb_count), 32'd0);
    chk("t5_rst_busy", 32'(drain_busy), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_count_after", 32'(sb_count), 32'd0);
    chk("t5_array_kept", rdata, 32'h0000_0A0A);

    // 6: aliasing, misaligned address, undefined command
    store(32'h1004, 32'h5);
    drive(BUS_LOAD, 32'h0004, 32'h0);
    chk("t6_alias_fwd", rdata, 32'h5);
    drive(BUS_LOAD, 32'h1007, 32'h0);
    chk("t6_misalign_fwd", rdata, 32'h5);
    wait_empty("t6_drain", 40);
    drive(BUS_LOAD, 32'h0004, 32'h0);
    chk("t6_alias_array", rdata, 32'h5);
    drive(2'd3, 32'h40, 32'h77);
    chk("t6_cmd3_data", rdata, 32'h0);
    tick();
    chk("t6_cmd3_nopush", 32'(sb_count), 32'd0);
    drive(BUS_NONE, 32'h40, 32'h0);
    chk("t6_none_data", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
